// File: rtl/i2c_write_master.sv
// Byte-level I2C write engine: serialises one 24-bit {addr, sub-addr, data} word per GO request.
// Optional build macro I2C_ABORT_ON_NACK_EN ends the bit phase at the first NACKed ack slot.
module i2c_write_master #(
  parameter int unsigned CLK_DIV = 625
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] tick_cnt_r, tick_cnt_s;
  logic [1:0]  phase_r, phase_s;
  logic [4:0]  bit_cnt_r, bit_cnt_s;
  logic [23:0] shift_r, shift_s;
  logic        nack_r, nack_s;
  logic        scl_r, scl_s;
  logic        sda_low_r, sda_low_s;
  logic        end_r, end_s;
  logic        ack_r, ack_s;
  logic        busy_r, busy_s;
  logic [1:0]  sda_sync_r;
  logic        tick_s;
  logic        ack_slot_s;
  logic        abort_s;

  assign tick_s     = (tick_cnt_r == 16'(CLK_DIV - 1));
  assign ack_slot_s = (bit_cnt_r == 5'd8) || (bit_cnt_r == 5'd17) || (bit_cnt_r == 5'd26);

`ifdef I2C_ABORT_ON_NACK_EN
  assign abort_s = ack_slot_s && nack_r;
`else
  assign abort_s = 1'b0;
`endif

  // Open-drain data line: only ever pulls low.
  assign I2C_SDAT = sda_low_r ? 1'b0 : 1'bz;
  assign I2C_SCLK = scl_r;
  assign oEND     = end_r;
  assign oACK     = ack_r;
  assign oBUSY    = busy_r;

  // Two-flop synchroniser for the externally driven data line.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sda_sync_r <= 2'b11;
    end else begin
      sda_sync_r <= {sda_sync_r[0], I2C_SDAT};
    end
  end

  // State and datapath register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= 16'd0;
      phase_r    <= 2'd0;
      bit_cnt_r  <= 5'd0;
      shift_r    <= 24'd0;
      nack_r     <= 1'b0;
      scl_r      <= 1'b1;
      sda_low_r  <= 1'b0;
      end_r      <= 1'b0;
      ack_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      tick_cnt_r <= tick_cnt_s;
      phase_r    <= phase_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      nack_r     <= nack_s;
      scl_r      <= scl_s;
      sda_low_r  <= sda_low_s;
      end_r      <= end_s;
      ack_r      <= ack_s;
      busy_r     <= busy_s;
    end
  end

  // Next-state and next-output logic; every bus action lands on a tick.
  always_comb begin
    state_s    = state_r;
    tick_cnt_s = tick_cnt_r;
    phase_s    = phase_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    nack_s     = nack_r;
    scl_s      = scl_r;
    sda_low_s  = sda_low_r;
    end_s      = end_r;
    ack_s      = ack_r;
    busy_s     = busy_r;

    if ((state_r == ST_IDLE) || (state_r == ST_DONE) || tick_s) begin
      tick_cnt_s = 16'd0;
    end else begin
      tick_cnt_s = tick_cnt_r + 16'd1;
    end

    case (state_r)
      ST_IDLE: begin
        if (iGO && !end_r) begin
          state_s = ST_START;
          shift_s = iDATA;
          nack_s  = 1'b0;
          ack_s   = 1'b0;
          busy_s  = 1'b1;
          phase_s = 2'd0;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_START: begin
        if (tick_s) begin
          if (phase_r == 2'd0) begin
            sda_low_s = 1'b1;
            phase_s   = 2'd1;
          end else begin
            scl_s     = 1'b0;
            state_s   = ST_BIT;
            bit_cnt_s = 5'd0;
            phase_s   = 2'd0;
          end
        end else begin
          phase_s = phase_r;
        end
      end
      ST_BIT: begin
        if (tick_s) begin
          case (phase_r)
            2'd0: begin
              sda_low_s = ack_slot_s ? 1'b0 : ~shift_r[23];
              phase_s   = 2'd1;
            end
            2'd1: begin
              scl_s   = 1'b1;
              phase_s = 2'd2;
            end
            2'd2: begin
              if (ack_slot_s && sda_sync_r[1]) begin
                nack_s = 1'b1;
              end else begin
                nack_s = nack_r;
              end
              phase_s = 2'd3;
            end
            default: begin
              scl_s   = 1'b0;
              phase_s = 2'd0;
              if (!ack_slot_s) begin
                shift_s = {shift_r[22:0], 1'b0};
              end else begin
                shift_s = shift_r;
              end
              if ((bit_cnt_r == 5'd26) || abort_s) begin
                state_s   = ST_STOP;
                bit_cnt_s = 5'd0;
              end else begin
                bit_cnt_s = bit_cnt_r + 5'd1;
              end
            end
          endcase
        end else begin
          phase_s = phase_r;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          case (phase_r)
            2'd0: begin
              sda_low_s = 1'b1;
              phase_s   = 2'd1;
            end
            2'd1: begin
              scl_s   = 1'b1;
              phase_s = 2'd2;
            end
            default: begin
              sda_low_s = 1'b0;
              end_s     = 1'b1;
              ack_s     = nack_r;
              busy_s    = 1'b0;
              phase_s   = 2'd0;
              state_s   = ST_DONE;
            end
          endcase
        end else begin
          phase_s = phase_r;
        end
      end
      ST_DONE: begin
        // Holding iGO high here must not retrigger; only a low level re-arms.
        if (!iGO) begin
          end_s   = 1'b0;
          state_s = ST_IDLE;
        end else begin
          end_s = 1'b1;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        scl_s     = 1'b1;
        sda_low_s = 1'b0;
        busy_s    = 1'b0;
        end_s     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Self-checking bench for i2c_write_master: directed vector table plus reset, hold and data-change sequences.
module tb_i2c_write_master;

  localparam int CLK_DIV = 4;

  typedef struct {
    logic [23:0] data;
    int          nack;
    logic [26:0] bus;
    int          bits;
    int          ticks;
    logic        ack;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [23:0] data = 24'd0;
  logic        end_o, ack_o, busy_o, scl;
  logic        slave_low = 1'b0;
  wire         sda_bus;

  pullup (sda_bus);
  assign sda_bus = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_write_master #(.CLK_DIV(CLK_DIV)) dut (
    .iCLK    (clk),
    .iRST_N  (rst_n),
    .iDATA   (data),
    .iGO     (go),
    .oEND    (end_o),
    .oACK    (ack_o),
    .oBUSY   (busy_o),
    .I2C_SCLK(scl),
    .I2C_SDAT(sda_bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          rise_cnt = 0;
  int          start_cnt = 0;
  int          stop_cnt = 0;
  int          nack_slot = 0;
  logic [31:0] rx_bits = 32'd0;
  logic        scl_prev = 1'b1;
  logic        sda_prev = 1'b1;

  // Slave model: detects START/STOP, records bits on SCL rise, ACKs on SCL fall.
  always @(sda_bus or scl) begin
    if (scl_prev === 1'b1 && scl === 1'b1 && sda_prev === 1'b1 && sda_bus === 1'b0) begin
      start_cnt = start_cnt + 1;
      rise_cnt  = 0;
      stop_cnt  = 0;
      slave_low = 1'b0;
    end else if (scl_prev === 1'b1 && scl === 1'b1 && sda_prev === 1'b0 && sda_bus === 1'b1) begin
      stop_cnt = stop_cnt + 1;
    end else if (scl_prev === 1'b0 && scl === 1'b1) begin
      if (rise_cnt < 32) rx_bits[rise_cnt] = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
      rise_cnt = rise_cnt + 1;
    end else if (scl_prev === 1'b1 && scl === 1'b0) begin
      slave_low = (rise_cnt == 8 || rise_cnt == 17 || rise_cnt == 26) && (rise_cnt != nack_slot);
    end
    scl_prev = scl;
    sda_prev = sda_bus;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_txn(input logic [23:0] d, input int nack, input logic [26:0] bus,
                         input int bits, input int ticks, input logic ack,
                         input int chg_bit, input logic [23:0] chg_data);
    int          cycles;
    int          s0;
    logic        seen;
    logic        changed;
    logic [26:0] rx;
    s0 = start_cnt;
    @(negedge clk);
    data = d;
    nack_slot = nack;
    go = 1'b1;
    cycles = 0;
    seen = 1'b0;
    changed = 1'b0;
    while (cycles < 3000 && !seen) begin
      @(posedge clk);
      #1;
      cycles = cycles + 1;
      if (cycles == 1) check("busy_after_start", busy_o, 1'b1);
      if (chg_bit >= 0 && !changed && rise_cnt >= chg_bit) begin
        data = chg_data;
        changed = 1'b1;
      end
      seen = end_o;
    end
    check("end_timeout", seen, 1'b1);
    check("end_latency", cycles, ticks * CLK_DIV + 1);
    check("busy_at_end", busy_o, 1'b0);
    check("ack_flag", ack_o, ack);
    rx = 27'd0;
    for (int i = 0; i < bits; i++) rx[26 - i] = rx_bits[i];
    check("bus_bits", rx, bus);
    check("scl_rises_incl_stop", rise_cnt, bits + 1);
    check("stop_seen", stop_cnt, 1);
    check("one_start", start_cnt, s0 + 1);
  endtask

  task automatic drop_go(input logic ack);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    check("end_clear", end_o, 1'b0);
    check("ack_hold", ack_o, ack);
    check("idle_scl", scl, 1'b1);
    check("idle_sda", sda_bus, 1'b1);
  endtask

  vec_t vecs[5];

  initial begin
    int   s;
    int   w;
    logic ok;

    repeat (3) @(posedge clk);
    #1;
    check("rst_end", end_o, 1'b0);
    check("rst_ack", ack_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda_bus, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{24'h341201, 0, 27'b001101000_000100100_000000010, 27, 113, 1'b0};
    vecs[2] = '{24'hA5FF00, 0, 27'b101001010_111111110_000000000, 27, 113, 1'b0};
    vecs[4] = '{24'h00FF81, 26, 27'b000000000_111111110_100000011, 27, 113, 1'b1};
`ifdef I2C_ABORT_ON_NACK_EN
    vecs[1] = '{24'h341201, 17, 27'b001101000_000100101_000000000, 18, 77, 1'b1};
    vecs[3] = '{24'h7E8001, 8, 27'b011111101_000000000_000000000, 9, 41, 1'b1};
`else
    vecs[1] = '{24'h341201, 17, 27'b001101000_000100101_000000010, 27, 113, 1'b1};
    vecs[3] = '{24'h7E8001, 8, 27'b011111101_100000000_000000010, 27, 113, 1'b1};
`endif

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].data, vecs[i].nack, vecs[i].bus, vecs[i].bits, vecs[i].ticks,
              vecs[i].ack, -1, 24'd0);
      drop_go(vecs[i].ack);
    end

    // GO held high after completion must not retrigger.
    run_txn(vecs[0].data, 0, vecs[0].bus, 27, 113, 1'b0, -1, 24'd0);
    s = start_cnt;
    ok = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (!end_o || busy_o) ok = 1'b0;
    end
    check("hold_end_high", ok, 1'b1);
    check("no_retrigger", start_cnt, s);
    drop_go(1'b0);

    // iDATA change mid-transfer is ignored; next word follows back-to-back.
    run_txn(24'h340C00, 0, 27'b001101000_000011000_000000000, 27, 113, 1'b0, 3, 24'h34FFFF);
    drop_go(1'b0);
    run_txn(24'h341201, 0, vecs[0].bus, 27, 113, 1'b0, -1, 24'd0);
    drop_go(1'b0);

    // Asynchronous reset during bit 10 releases the bus at once.
    @(negedge clk);
    data = 24'h341201;
    nack_slot = 0;
    go = 1'b1;
    w = 0;
    while (w < 2000 && rise_cnt < 11) begin
      @(posedge clk);
      #1;
      w = w + 1;
    end
    check("reach_bit10", rise_cnt >= 11, 1'b1);
    #2;
    rst_n = 1'b0;
    go = 1'b0;
    #1;
    check("mid_rst_scl", scl, 1'b1);
    check("mid_rst_sda", sda_bus, 1'b1);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_end", end_o, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(vecs[0].data, 0, vecs[0].bus, 27, 113, 1'b0, -1, 24'd0);
    drop_go(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
